// File: rtl/cr_tlvp_usr_arb_if.sv
// TLV word type and the bundled requester/user-FIFO bus shared by the
// cr_tlvp_usr_arb arbiter and its environment.
package cr_tlvp_pkg;
   typedef struct packed {
      logic        sot;
      logic        eot;
      logic [15:0] data;
   } tlvp_if_bus_t;
endpackage

interface cr_tlvp_usr_arb_if #(
   parameter int N_REQ = 4
);
   import cr_tlvp_pkg::*;

   logic [N_REQ-1:0]         req_empty;
   tlvp_if_bus_t [N_REQ-1:0] req_tlv;
   logic [N_REQ-1:0]         req_rd;
   logic                     usr_full;
   logic                     usr_afull;
   logic                     usr_wr;
   tlvp_if_bus_t             usr_tlv;

   // master is the arbiter side, slave is the requesters plus user FIFO
   modport master (
      input  req_empty, req_tlv, usr_full, usr_afull,
      output req_rd, usr_wr, usr_tlv
   );

   modport slave (
      output req_empty, req_tlv, usr_full, usr_afull,
      input  req_rd, usr_wr, usr_tlv
   );
endinterface

// File: rtl/cr_tlvp_usr_arb.sv
// Frame-atomic round-robin arbiter sharing the TLV parser user-insert port
// between N_REQ FWFT requesters; a grant is held until its eot word is forwarded.
module cr_tlvp_usr_arb
   import cr_tlvp_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int OW    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   cr_tlvp_usr_arb_if.master   bus,
   output logic                locked,
   output logic [OW-1:0]       cur_owner,
   output logic                frame_done,
   output logic                sot_err
);

   localparam int OW1 = OW + 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t         state_r;
   logic [OW-1:0]  rr_ptr_r;
   logic [OW-1:0]  cur_owner_r;
   logic           usr_wr_r;
   tlvp_if_bus_t   usr_tlv_r;
   logic           frame_done_r;
   logic           sot_err_r;

   logic [OW-1:0]  cand_s;
   logic           cand_vld_s;
   logic           stall_s;
   logic [OW-1:0]  sel_s;
   logic           pop_s;
   logic [N_REQ-1:0] req_rd_s;
   tlvp_if_bus_t   word_s;
   logic [OW-1:0]  nxt_ptr_s;

   function automatic logic [OW-1:0] inc_wrap(input logic [OW-1:0] v);
      if (v == OW'(N_REQ - 1)) begin
         return {OW{1'b0}};
      end else begin
         return v + {{(OW-1){1'b0}}, 1'b1};
      end
   endfunction

   // Round-robin candidate: first non-empty requester at or after rr_ptr.
   always_comb begin
      logic [OW:0] sum;
      logic [OW:0] idx;
      logic        hit;
      cand_s     = {OW{1'b0}};
      cand_vld_s = 1'b0;
      sum        = {OW1{1'b0}};
      idx        = {OW1{1'b0}};
      hit        = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sum        = {1'b0, rr_ptr_r} + OW1'(i);
         idx        = (sum >= OW1'(N_REQ)) ? (sum - OW1'(N_REQ)) : sum;
         hit        = !cand_vld_s && !bus.req_empty[idx[OW-1:0]];
         cand_s     = hit ? idx[OW-1:0] : cand_s;
         cand_vld_s = cand_vld_s | hit;
      end
   end

   // Pop decision: the owner alone is served while locked; nothing moves in reset or stall.
   always_comb begin
      stall_s   = bus.usr_afull | bus.usr_full;
      sel_s     = (state_r == ST_LOCKED) ? cur_owner_r : cand_s;
      pop_s     = rst_n & ~stall_s &
                  ((state_r == ST_LOCKED) ? ~bus.req_empty[cur_owner_r] : cand_vld_s);
      req_rd_s  = pop_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_s) : {N_REQ{1'b0}};
      word_s    = bus.req_tlv[sel_s];
      nxt_ptr_s = inc_wrap(sel_s);
   end

   // Arbitration FSM plus the registered user-port outputs and status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         rr_ptr_r     <= {OW{1'b0}};
         cur_owner_r  <= {OW{1'b0}};
         usr_wr_r     <= 1'b0;
         usr_tlv_r    <= '0;
         frame_done_r <= 1'b0;
         sot_err_r    <= 1'b0;
      end else begin
         usr_wr_r     <= pop_s;
         usr_tlv_r    <= pop_s ? word_s : usr_tlv_r;
         frame_done_r <= pop_s & word_s.eot;
         sot_err_r    <= pop_s & ((state_r == ST_LOCKED) ? word_s.sot : ~word_s.sot);
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  cur_owner_r <= cand_s;
                  if (word_s.eot) begin
                     rr_ptr_r <= nxt_ptr_s;
                  end else begin
                     state_r <= ST_LOCKED;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (pop_s && word_s.eot) begin
                  state_r  <= ST_IDLE;
                  rr_ptr_r <= nxt_ptr_s;
               end else begin
                  state_r <= ST_LOCKED;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_rd  = req_rd_s;
   assign bus.usr_wr  = usr_wr_r;
   assign bus.usr_tlv = usr_tlv_r;
   assign locked      = (state_r == ST_LOCKED);
   assign cur_owner   = cur_owner_r;
   assign frame_done  = frame_done_r;
   assign sot_err     = sot_err_r;

endmodule

// File: tb/tb_cr_tlvp_usr_arb.sv
// Directed bench for cr_tlvp_usr_arb: requesters are modelled as word queues,
// each scenario checks hand-computed grant, output and status values.
module tb_cr_tlvp_usr_arb;
   import cr_tlvp_pkg::*;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked;
   logic [1:0] cur_owner;
   logic       frame_done;
   logic       sot_err;
   int         vectors = 0;
   int         miscompares = 0;
   tlvp_if_bus_t q [N][$];
   logic [N-1:0] rd_smp;

   cr_tlvp_usr_arb_if #(.N_REQ(N)) bus ();

   cr_tlvp_usr_arb #(.N_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .locked     (locked),
      .cur_owner  (cur_owner),
      .frame_done (frame_done),
      .sot_err    (sot_err)
   );

   always #5 clk = ~clk;

   function automatic tlvp_if_bus_t mk(input logic s, input logic e, input logic [15:0] d);
      tlvp_if_bus_t w;
      w.sot = s; w.eot = e; w.data = d;
      return w;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         bus.req_empty[i] = (q[i].size() == 0);
         bus.req_tlv[i]   = (q[i].size() == 0) ? mk(1'b0, 1'b0, 16'h0000) : q[i][0];
      end
   endtask

   // one clock: sample req_rd before the edge, pop the read queue after it
   task automatic tick();
      #1;
      rd_smp = bus.req_rd;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rd_smp[i]) begin
            if (q[i].size() == 0) begin
               $display("FAIL rd_on_empty req%0d got read want no read", i);
               miscompares++;
            end else begin
               void'(q[i].pop_front());
            end
         end
      end
      drive_reqs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.usr_full = 1'b0;
      bus.usr_afull = 1'b0;
      for (int i = 0; i < N; i++) q[i].delete();
      q[0].push_back(mk(1'b1, 1'b1, 16'h0abc));
      drive_reqs();
      tick();
      tick();
      #1;
      vectors++; if (bus.req_rd !== 4'b0000) begin $display("FAIL reset_req_rd got %b want %b", bus.req_rd, 4'b0000); miscompares++; end
      vectors++; if (bus.usr_wr !== 1'b0) begin $display("FAIL reset_usr_wr got %b want 0", bus.usr_wr); miscompares++; end
      vectors++; if (bus.usr_tlv !== 18'h00000) begin $display("FAIL reset_usr_tlv got %h want 0", bus.usr_tlv); miscompares++; end
      vectors++; if (locked !== 1'b0) begin $display("FAIL reset_locked got %b want 0", locked); miscompares++; end
      vectors++; if (cur_owner !== 2'd0) begin $display("FAIL reset_cur_owner got %0d want 0", cur_owner); miscompares++; end
      vectors++; if ({frame_done, sot_err} !== 2'b00) begin $display("FAIL reset_pulses got %b want 00", {frame_done, sot_err}); miscompares++; end
      q[0].delete();
      drive_reqs();
      rst_n = 1'b1;
   endtask

   task automatic test_single_frame();
      q[2].push_back(mk(1'b1, 1'b0, 16'h2000));
      q[2].push_back(mk(1'b0, 1'b0, 16'h2001));
      q[2].push_back(mk(1'b0, 1'b1, 16'h2002));
      drive_reqs();
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++; if (bus.req_rd !== 4'b0100) begin $display("FAIL single_req_rd cyc%0d got %b want 0100", k, bus.req_rd); miscompares++; end
         tick();
         vectors++; if (bus.usr_wr !== 1'b1) begin $display("FAIL single_usr_wr cyc%0d got %b want 1", k, bus.usr_wr); miscompares++; end
         vectors++; if (bus.usr_tlv.data !== 16'(16'h2000 + k)) begin $display("FAIL single_data cyc%0d got %h want %h", k, bus.usr_tlv.data, 16'(16'h2000 + k)); miscompares++; end
         vectors++; if (locked !== (k < 2)) begin $display("FAIL single_locked cyc%0d got %b want %b", k, locked, (k < 2)); miscompares++; end
         vectors++; if (frame_done !== (k == 2)) begin $display("FAIL single_frame_done cyc%0d got %b want %b", k, frame_done, (k == 2)); miscompares++; end
      end
      tick();
      vectors++; if (bus.usr_wr !== 1'b0) begin $display("FAIL single_idle_wr got %b want 0", bus.usr_wr); miscompares++; end
      vectors++; if (dut.rr_ptr_r !== 2'd3) begin $display("FAIL single_rr_ptr got %0d want 3", dut.rr_ptr_r); miscompares++; end
   endtask

   task automatic test_round_robin();
      int r;
      int f;
      int w;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int rr = 0; rr < N; rr++) begin
         for (int ff = 0; ff < 2; ff++) begin
            q[rr].push_back(mk(1'b1, 1'b0, 16'(rr * 256 + ff * 16)));
            q[rr].push_back(mk(1'b0, 1'b1, 16'(rr * 256 + ff * 16 + 1)));
         end
      end
      drive_reqs();
      for (int k = 0; k < 16; k++) begin
         tick();
         r = (k / 2) % 4;
         f = k / 8;
         w = k % 2;
         vectors++; if (bus.usr_wr !== 1'b1) begin $display("FAIL rr_usr_wr word%0d got %b want 1", k, bus.usr_wr); miscompares++; end
         vectors++; if (bus.usr_tlv.data !== 16'(r * 256 + f * 16 + w)) begin $display("FAIL rr_data word%0d got %h want %h", k, bus.usr_tlv.data, 16'(r * 256 + f * 16 + w)); miscompares++; end
         vectors++; if (locked !== (w == 0)) begin $display("FAIL rr_locked word%0d got %b want %b", k, locked, (w == 0)); miscompares++; end
         vectors++; if (cur_owner !== 2'(r)) begin $display("FAIL rr_owner word%0d got %0d want %0d", k, cur_owner, r); miscompares++; end
      end
      tick();
      vectors++; if (bus.usr_wr !== 1'b0) begin $display("FAIL rr_drain_wr got %b want 0", bus.usr_wr); miscompares++; end
   endtask

   task automatic test_owner_bubble();
      q[0].push_back(mk(1'b1, 1'b1, 16'h0a00));
      drive_reqs();
      tick();
      vectors++; if (frame_done !== 1'b1) begin $display("FAIL bubble_single_done got %b want 1", frame_done); miscompares++; end
      q[1].push_back(mk(1'b1, 1'b0, 16'h1b00));
      q[0].push_back(mk(1'b1, 1'b0, 16'h0c00));
      q[0].push_back(mk(1'b0, 1'b1, 16'h0c01));
      drive_reqs();
      #1;
      vectors++; if (bus.req_rd !== 4'b0010) begin $display("FAIL bubble_grant1 got %b want 0010", bus.req_rd); miscompares++; end
      tick();
      vectors++; if (bus.usr_tlv.data !== 16'h1b00) begin $display("FAIL bubble_sot_data got %h want 1b00", bus.usr_tlv.data); miscompares++; end
      vectors++; if ({locked, cur_owner} !== 3'b101) begin $display("FAIL bubble_lock got %b want 101", {locked, cur_owner}); miscompares++; end
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors++; if (bus.req_rd !== 4'b0000) begin $display("FAIL bubble_hold_rd cyc%0d got %b want 0000", k, bus.req_rd); miscompares++; end
         tick();
         vectors++; if (bus.usr_wr !== 1'b0) begin $display("FAIL bubble_hold_wr cyc%0d got %b want 0", k, bus.usr_wr); miscompares++; end
      end
      q[1].push_back(mk(1'b0, 1'b1, 16'h1b01));
      drive_reqs();
      #1;
      vectors++; if (bus.req_rd !== 4'b0010) begin $display("FAIL bubble_refill_rd got %b want 0010", bus.req_rd); miscompares++; end
      tick();
      vectors++; if (bus.usr_tlv.data !== 16'h1b01 || frame_done !== 1'b1) begin $display("FAIL bubble_eot got %h/%b want 1b01/1", bus.usr_tlv.data, frame_done); miscompares++; end
      #1;
      vectors++; if (bus.req_rd !== 4'b0001) begin $display("FAIL bubble_next_grant got %b want 0001", bus.req_rd); miscompares++; end
      tick();
      vectors++; if (bus.usr_tlv.data !== 16'h0c00) begin $display("FAIL bubble_c0 got %h want 0c00", bus.usr_tlv.data); miscompares++; end
      tick();
      vectors++; if (bus.usr_tlv.data !== 16'h0c01) begin $display("FAIL bubble_c1 got %h want 0c01", bus.usr_tlv.data); miscompares++; end
   endtask

   task automatic test_backpressure();
      int  idx = 0;
      logic wr_exp;
      for (int k = 0; k < 10; k++) q[0].push_back(mk(k == 0, k == 9, 16'(16'h0d00 + k)));
      drive_reqs();
      for (int c = 0; c < 16; c++) begin
         bus.usr_afull = (c >= 4 && c <= 9);
         bus.usr_full  = (c == 6 || c == 7);
         wr_exp = !(c >= 4 && c <= 9);
         #1;
         vectors++; if (bus.req_rd !== (wr_exp ? 4'b0001 : 4'b0000)) begin $display("FAIL bp_req_rd cyc%0d got %b want %b", c, bus.req_rd, (wr_exp ? 4'b0001 : 4'b0000)); miscompares++; end
         tick();
         vectors++; if (bus.usr_wr !== wr_exp) begin $display("FAIL bp_usr_wr cyc%0d got %b want %b", c, bus.usr_wr, wr_exp); miscompares++; end
         vectors++; if ((bus.usr_wr & bus.usr_full) !== 1'b0) begin $display("FAIL bp_wr_when_full cyc%0d got 1 want 0", c); miscompares++; end
         if (wr_exp) begin
            vectors++; if (bus.usr_tlv.data !== 16'(16'h0d00 + idx)) begin $display("FAIL bp_order cyc%0d got %h want %h", c, bus.usr_tlv.data, 16'(16'h0d00 + idx)); miscompares++; end
            idx++;
         end
      end
      bus.usr_afull = 1'b0;
      bus.usr_full  = 1'b0;
      vectors++; if (frame_done !== 1'b1) begin $display("FAIL bp_frame_done got %b want 1", frame_done); miscompares++; end
   endtask

   task automatic test_protocol_wrap();
      q[3].push_back(mk(1'b0, 1'b0, 16'h3e00));
      q[3].push_back(mk(1'b0, 1'b1, 16'h3e01));
      drive_reqs();
      #1;
      vectors++; if (bus.req_rd !== 4'b1000) begin $display("FAIL proto_grant3 got %b want 1000", bus.req_rd); miscompares++; end
      tick();
      vectors++; if (sot_err !== 1'b1 || bus.usr_tlv.data !== 16'h3e00) begin $display("FAIL proto_missing_sot got %b/%h want 1/3e00", sot_err, bus.usr_tlv.data); miscompares++; end
      tick();
      vectors++; if (sot_err !== 1'b0 || frame_done !== 1'b1) begin $display("FAIL proto_eot got %b/%b want 0/1", sot_err, frame_done); miscompares++; end
      vectors++; if (dut.rr_ptr_r !== 2'd0) begin $display("FAIL proto_wrap got %0d want 0", dut.rr_ptr_r); miscompares++; end
      q[0].push_back(mk(1'b1, 1'b0, 16'h0f00));
      q[0].push_back(mk(1'b1, 1'b0, 16'h0f01));
      q[0].push_back(mk(1'b0, 1'b1, 16'h0f02));
      drive_reqs();
      tick();
      vectors++; if (sot_err !== 1'b0) begin $display("FAIL proto_good_sot got %b want 0", sot_err); miscompares++; end
      tick();
      vectors++; if (sot_err !== 1'b1 || bus.usr_tlv.data !== 16'h0f01) begin $display("FAIL proto_mid_sot got %b/%h want 1/0f01", sot_err, bus.usr_tlv.data); miscompares++; end
      tick();
      vectors++; if (sot_err !== 1'b0 || frame_done !== 1'b1) begin $display("FAIL proto_end got %b/%b want 0/1", sot_err, frame_done); miscompares++; end
   endtask

   task automatic test_reset_midframe();
      for (int k = 0; k < 4; k++) q[1].push_back(mk(k == 0, k == 3, 16'(16'h1100 + k)));
      q[0].push_back(mk(1'b1, 1'b1, 16'h0100));
      drive_reqs();
      tick();
      tick();
      vectors++; if (bus.usr_tlv.data !== 16'h1101 || locked !== 1'b1) begin $display("FAIL mid_before got %h/%b want 1101/1", bus.usr_tlv.data, locked); miscompares++; end
      rst_n = 1'b0;
      #1;
      vectors++; if (bus.req_rd !== 4'b0000) begin $display("FAIL mid_rst_rd got %b want 0000", bus.req_rd); miscompares++; end
      tick();
      vectors++; if (bus.usr_wr !== 1'b0 || bus.usr_tlv !== 18'h00000) begin $display("FAIL mid_rst_usr got %b/%h want 0/0", bus.usr_wr, bus.usr_tlv); miscompares++; end
      vectors++; if ({locked, cur_owner, frame_done, sot_err} !== 5'b00000) begin $display("FAIL mid_rst_status got %b want 00000", {locked, cur_owner, frame_done, sot_err}); miscompares++; end
      vectors++; if (dut.rr_ptr_r !== 2'd0) begin $display("FAIL mid_rst_ptr got %0d want 0", dut.rr_ptr_r); miscompares++; end
      q[1].delete();
      drive_reqs();
      rst_n = 1'b1;
      #1;
      vectors++; if (bus.req_rd !== 4'b0001) begin $display("FAIL mid_regrant got %b want 0001", bus.req_rd); miscompares++; end
      tick();
      vectors++; if (bus.usr_wr !== 1'b1 || bus.usr_tlv.data !== 16'h0100) begin $display("FAIL mid_after got %b/%h want 1/0100", bus.usr_wr, bus.usr_tlv.data); miscompares++; end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_owner_bubble();
      test_backpressure();
      test_protocol_wrap();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
